// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, the load/store requester and the memory
//   port of the shared single-port memory arbiter.
//
//   slave  : the arbiter side (takes requests and mem_rdata, drives grants,
//            read returns and the memory strobe/bus).
//   master : the environment side (fetch stage, LS stage and memory array).
//
//   Signals
//     if_req/if_addr                  fetch read request and address
//     if_gnt/if_rvalid/if_rdata       fetch grant pulse and read return
//     ls_req/ls_we/ls_addr/ls_wdata   LS request, direction and operands
//     ls_gnt/ls_rvalid/ls_rdata       LS grant pulse and read return
//     mem_en/mem_we/mem_addr/mem_wdata  memory access strobe and bus
//     mem_rdata                       memory read data
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the CPU's single-port memory between instruction fetch (IF) and
//   the load/store unit (LS). One transaction is in flight at a time; LS has
//   priority, except that after STARVE_LIM back-to-back LS wins while fetch
//   was waiting, fetch is granted next. Reads wait out the memory's fixed
//   latency and the returned data is steered to the winning requester.
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset (0 = in reset)
//     bus    mem_port_arbiter_if.slave: requests, grants, read returns and
//            the memory port
//     busy   high whenever a transaction is being issued or awaited
//
//   Timing (decision edge N)
//     cycle N+1           : gnt pulse, mem_en (and mem_we for writes)
//     cycle N+1+MEM_LAT   : rvalid + rdata for reads
//     next decision       : end of the first cycle back in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  // Access latched at the decision edge; it also directly drives the memory
  // bus, so it is only non-zero during ISSUE.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_e      state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic        win_ls_q,    win_ls_d;
  acc_t        acc_q,       acc_d;
  logic        mem_en_q,    mem_en_d;
  logic        if_gnt_q,    if_gnt_d;
  logic        ls_gnt_q,    ls_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic        busy_q,      busy_d;
  logic        rv_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    win_ls_d = win_ls_q;
    acc_d    = '0;
    mem_en_d = 1'b0;
    if_gnt_d = 1'b0;
    ls_gnt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          // LS wins unless fetch has been passed over STARVE_LIM times.
          win_ls_d = bus.ls_req &&
                     !(bus.if_req && (streak_q == STK_W'(STARVE_LIM)));
          // An LS win with fetch waiting can only happen below the limit,
          // so the increment never passes STARVE_LIM.
          if (win_ls_d && bus.if_req) streak_d = streak_q + STK_W'(1);
          else                        streak_d = '0;
          if (win_ls_d)
            acc_d = '{we: bus.ls_we, addr: bus.ls_addr, wdata: bus.ls_wdata};
          else
            acc_d = '{we: 1'b0, addr: bus.if_addr, wdata: '0};
          mem_en_d = 1'b1;
          if_gnt_d = !win_ls_d;
          ls_gnt_d = win_ls_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (acc_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // rvalid is registered: raise it for the cycle that will be the last
    // WAIT cycle (counter == 1). Covers MEM_LAT == 1 straight from ISSUE.
    rv_d        = (state_d == WAIT) && (cnt_d == CNT_W'(1));
    if_rvalid_d = rv_d && !win_ls_q;
    ls_rvalid_d = rv_d &&  win_ls_q;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      win_ls_q    <= 1'b0;
      acc_q       <= '0;
      mem_en_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      win_ls_q    <= win_ls_d;
      acc_q       <= acc_d;
      mem_en_q    <= mem_en_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  // Read data is a passthrough of the memory, gated so it is 0 off-valid.
  assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rvalid_q ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = acc_q.we;
  assign bus.mem_addr  = acc_q.addr;
  assign bus.mem_wdata = acc_q.wdata;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized requesters plus a latency-accurate memory drive the arbiter.
//   A transaction-level reference decides each arbitration from the rules
//   (priority, starvation streak, one-at-a-time occupancy) and predicts the
//   cycle of each grant and read return; every output is compared each
//   cycle on the falling edge.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_LIM = 4;
  localparam int NCYC       = 3000;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  // ---------------- memory environment ----------------
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 8'h04) return 16'hBEEF;
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  logic [DATA_W-1:0] env_mem [256];
  bit                mem_init = 1'b0;
  bit                pipe_v [MEM_LAT];
  logic [ADDR_W-1:0] pipe_a [MEM_LAT];
  logic [DATA_W-1:0] junk = 16'h0bad;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) env_mem[a] <= init_val(8'(a));
      mem_init <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_a[0] <= bus.mem_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_a[k] <= pipe_a[k-1];
    end
    junk <= 16'($urandom);
  end

  // Read data appears MEM_LAT cycles after the mem_en cycle; garbage otherwise.
  assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? env_mem[pipe_a[MEM_LAT-1]] : junk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [256];
  int   cyc, n_chk, n_fail;
  int   m_gnt_c, m_rv_c, m_end_c, m_free, streak;
  bit   m_ls, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  int   p_if, p_ls, p_wr, p_drop, rst_hold, n_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt_c = -100; m_rv_c = -100; m_end_c = -100;
    m_free  = 0;    streak = 0;
  endtask

  // Arbitration at the rising edge that opens cycle e.
  task automatic model_edge();
    int e;
    e = cyc + 1;
    if (e >= m_free && (bus.if_req || bus.ls_req)) begin
      m_ls = bus.ls_req && !(bus.if_req && streak == STARVE_LIM);
      if (m_ls && bus.if_req) streak = (streak < STARVE_LIM) ? streak + 1 : STARVE_LIM;
      else                    streak = 0;
      m_gnt_c = e;
      if (m_ls) begin
        m_we = bus.ls_we; m_addr = bus.ls_addr; m_wdata = bus.ls_wdata;
      end else begin
        m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0;
      end
      if (m_we) begin
        ref_mem[m_addr] = m_wdata;
        m_rv_c = -100; m_end_c = e; m_free = e + 2;
      end else begin
        m_rdata = ref_mem[m_addr];
        m_rv_c = e + MEM_LAT; m_end_c = e + MEM_LAT; m_free = e + MEM_LAT + 2;
      end
    end
  endtask

  task automatic check_cycle();
    bit iss, rv;
    iss = (cyc == m_gnt_c);
    rv  = (cyc == m_rv_c);
    chk("if_gnt",    32'(bus.if_gnt),    32'(iss && !m_ls));
    chk("ls_gnt",    32'(bus.ls_gnt),    32'(iss &&  m_ls));
    chk("mem_en",    32'(bus.mem_en),    32'(iss));
    chk("mem_we",    32'(bus.mem_we),    32'(iss && m_we));
    chk("mem_addr",  32'(bus.mem_addr),  iss ? 32'(m_addr) : 32'd0);
    if (!iss || m_we)
      chk("mem_wdata", 32'(bus.mem_wdata), iss ? 32'(m_wdata) : 32'd0);
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(rv && !m_ls));
    chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(rv &&  m_ls));
    chk("if_rdata",  32'(bus.if_rdata),  (rv && !m_ls) ? 32'(m_rdata) : 32'd0);
    chk("ls_rdata",  32'(bus.ls_rdata),  (rv &&  m_ls) ? 32'(m_rdata) : 32'd0);
    chk("busy",      32'(busy),          32'(cyc >= m_gnt_c && cyc <= m_end_c));
  endtask

  // Requesters: hold req and operands until a grant is seen, may drop early.
  task automatic drive();
    bit ig, lg;
    ig = (cyc == m_gnt_c) && !m_ls;
    lg = (cyc == m_gnt_c) &&  m_ls;
    if (bus.if_req) begin
      if (ig) begin
        bus.if_req  = ($urandom_range(99) < p_if);
        bus.if_addr = 8'($urandom);
      end else if ($urandom_range(99) < p_drop) begin
        bus.if_req = 1'b0;
      end
    end else begin
      bus.if_req  = ($urandom_range(99) < p_if);
      bus.if_addr = 8'($urandom);
    end
    if (bus.ls_req && !lg) begin
      if ($urandom_range(99) < p_drop) bus.ls_req = 1'b0;
    end else begin
      bus.ls_req   = ($urandom_range(99) < p_ls);
      bus.ls_we    = ($urandom_range(99) < p_wr);
      bus.ls_addr  = 8'($urandom);
      bus.ls_wdata = 16'($urandom);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; n_rst = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
    model_reset();
    m_ls = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    reset        = 1'b0;
    bus.if_req   = 1'b1; bus.if_addr  = 8'h04;
    bus.ls_req   = 1'b1; bus.ls_we    = 1'b1;
    bus.ls_addr  = 8'h20; bus.ls_wdata = 16'h1234;
    p_if = 100; p_ls = 0; p_wr = 100; p_drop = 0;
    rst_hold = 3;
    #1 check_cycle();

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      cyc++;
      check_cycle();
      if (cyc > 80) begin
        p_if = 40; p_ls = 50; p_wr = 40; p_drop = 5;
      end else if (cyc > 20) begin
        p_if = 100; p_ls = 100; p_wr = 0; p_drop = 0;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if (cyc > 100 && !m_ls && cyc > m_gnt_c && cyc < m_rv_c &&
                   $urandom_range(99) < 30) begin
        // Abandon a fetch read mid-WAIT: outputs must drop at once.
        #2 reset = 1'b0;
        model_reset();
        #1 check_cycle();
        rst_hold = 2;
        n_rst++;
      end
      drive();
      if (reset) model_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
